// File: rtl/maze_dfs_engine.sv
// Depth-first maze solver. Walks a ROWS x COLS grid held in external
// 1-bit memory (1 = wall or already visited), marks each cell it enters,
// keeps the move history on an internal stack and streams that history
// out as the path once the goal cell is reached.
// Optional build macro MAZE_STEP_LIMIT_EN: bounds the search to MAX_STEPS
// moves (ADVANCE + BACKTRACK) and reports exhaustion through timeout.
//
// state      | meaning
// IDLE       | waiting for start
// INIT       | search registers loaded
// CHECK_GOAL | compare current cell with goal
// MARK       | write visited bit for current cell
// PROBE      | bounds-check neighbour in dir, issue read if inside
// WAIT_RD    | hold neighbour address until read data returns
// ADVANCE    | push dir, step into neighbour
// NEXT_DIR   | try next direction or give up on this cell
// BACKTRACK  | pop last move and step back
// EMIT       | stream stack bottom-to-top on path handshake
// DONE       | path available, replay allowed
// FAIL       | no path (or step limit hit)
module maze_dfs_engine #(
  parameter int W         = 4,
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int DEPTH     = 256,
  parameter int MAX_STEPS = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [W-1:0]             start_x,
  input  logic [W-1:0]             start_y,
  input  logic [W-1:0]             goal_x,
  input  logic [W-1:0]             goal_y,
  output logic [2*W-1:0]           mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  input  logic                     mem_rdata,
  input  logic                     mem_rvalid,
  output logic [1:0]               path_dir,
  output logic                     path_valid,
  input  logic                     path_ready,
  input  logic                     replay,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   path_len
);

  localparam int SPW = $clog2(DEPTH);
  localparam logic [W:0] COLS_L = (W+1)'(COLS);
  localparam logic [W:0] ROWS_L = (W+1)'(ROWS);

  typedef enum logic [3:0] {
    IDLE, INIT, CHECK_GOAL, MARK, PROBE, WAIT_RD,
    ADVANCE, NEXT_DIR, BACKTRACK, EMIT, DONE, FAIL
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   pos_x_q, pos_y_q, goal_x_q, goal_y_q;
  logic [1:0]     dir_q;
  logic [SPW:0]   sp_q, emit_idx_q, path_len_q;
  logic [1:0]     stack_mem [DEPTH];

  logic [2*W-1:0] nb_pos, bt_pos;
  logic           nb_oob, sp_full, sp_empty, at_goal, emit_last, limit_hit;
  logic [SPW-1:0] sp_top;
  logic [1:0]     top_dir;

  // {y,x} after one move in direction d; wrap is harmless because
  // out-of-range moves are rejected before use.
  function automatic logic [2*W-1:0] step_pos(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic [1:0] d);
    logic [W-1:0] nx, ny;
    nx = x;
    ny = y;
    case (d)
      2'd0: nx = x + W'(1);
      2'd1: ny = y + W'(1);
      2'd2: nx = x - W'(1);
      default: ny = y - W'(1);
    endcase
    return {ny, nx};
  endfunction

  assign sp_full   = sp_q[SPW];
  assign sp_empty  = (sp_q == '0);
  assign sp_top    = sp_q[SPW-1:0] - SPW'(1);
  assign top_dir   = stack_mem[sp_top];
  assign nb_pos    = step_pos(pos_x_q, pos_y_q, dir_q);
  assign bt_pos    = step_pos(pos_x_q, pos_y_q, top_dir ^ 2'd2);
  assign at_goal   = (pos_x_q == goal_x_q) && (pos_y_q == goal_y_q);
  assign emit_last = ((emit_idx_q + (SPW+1)'(1)) == path_len_q);
  assign path_len  = path_len_q;
  assign busy      = !(state_q == IDLE || state_q == DONE || state_q == FAIL);
  assign done      = (state_q == DONE);
  assign fail      = (state_q == FAIL);

  // Neighbour bounds check for the direction currently being probed.
  always_comb begin
    nb_oob = 1'b0;
    case (dir_q)
      2'd0: nb_oob = (({1'b0, pos_x_q} + (W+1)'(1)) >= COLS_L);
      2'd1: nb_oob = (({1'b0, pos_y_q} + (W+1)'(1)) >= ROWS_L);
      2'd2: nb_oob = (pos_x_q == '0);
      default: nb_oob = (pos_y_q == '0);
    endcase
  end

`ifdef MAZE_STEP_LIMIT_EN
  localparam int STW = $clog2(MAX_STEPS + 1);
  logic [STW-1:0] step_q;
  logic           timeout_q;
  assign limit_hit = (step_q == STW'(MAX_STEPS - 1));
  assign timeout   = timeout_q;

  // Move counter; the move that reaches MAX_STEPS flags timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q    <= '0;
      timeout_q <= 1'b0;
    end else if ((state_q == IDLE || state_q == DONE || state_q == FAIL) && start) begin
      timeout_q <= 1'b0;
    end else if (state_q == INIT) begin
      step_q <= '0;
    end else if ((state_q == ADVANCE && !sp_full) || state_q == BACKTRACK) begin
      step_q <= step_q + STW'(1);
      if (limit_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and memory/path strobes.
  always_comb begin
    state_d    = state_q;
    mem_addr   = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    path_valid = 1'b0;
    path_dir   = 2'd0;
    case (state_q)
      IDLE, FAIL: if (start) state_d = INIT;
      DONE: begin
        if (start)       state_d = INIT;
        else if (replay) state_d = EMIT;
      end
      INIT:       state_d = CHECK_GOAL;
      CHECK_GOAL: state_d = at_goal ? EMIT : MARK;
      MARK: begin
        mem_wr   = 1'b1;
        mem_addr = {pos_y_q, pos_x_q};
        state_d  = PROBE;
      end
      PROBE: begin
        if (nb_oob) begin
          state_d = NEXT_DIR;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = nb_pos;
          state_d  = WAIT_RD;
        end
      end
      WAIT_RD: begin
        mem_addr = nb_pos;
        if (mem_rvalid) state_d = mem_rdata ? NEXT_DIR : ADVANCE;
      end
      ADVANCE: begin
        if (sp_full || limit_hit) state_d = FAIL;
        else                      state_d = CHECK_GOAL;
      end
      NEXT_DIR: begin
        if (dir_q != 2'd3) state_d = PROBE;
        else if (sp_empty) state_d = FAIL;
        else               state_d = BACKTRACK;
      end
      BACKTRACK: state_d = limit_hit ? FAIL : NEXT_DIR;
      EMIT: begin
        if (emit_idx_q == path_len_q) begin
          state_d = DONE;
        end else begin
          path_valid = 1'b1;
          path_dir   = stack_mem[emit_idx_q[SPW-1:0]];
          if (path_ready && emit_last) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Search datapath: position, direction, stack pointer and emit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      goal_x_q   <= '0;
      goal_y_q   <= '0;
      dir_q      <= 2'd0;
      sp_q       <= '0;
      emit_idx_q <= '0;
      path_len_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, FAIL: begin
          if (start) begin
            pos_x_q    <= start_x;
            pos_y_q    <= start_y;
            goal_x_q   <= goal_x;
            goal_y_q   <= goal_y;
            dir_q      <= 2'd0;
            sp_q       <= '0;
            emit_idx_q <= '0;
            path_len_q <= '0;
          end else if (state_q == DONE && replay) begin
            emit_idx_q <= '0;
          end
        end
        CHECK_GOAL: begin
          if (at_goal) begin
            path_len_q <= sp_q;
            emit_idx_q <= '0;
          end
        end
        ADVANCE: begin
          if (!sp_full) begin
            sp_q               <= sp_q + (SPW+1)'(1);
            {pos_y_q, pos_x_q} <= nb_pos;
            dir_q              <= 2'd0;
          end
        end
        NEXT_DIR: if (dir_q != 2'd3) dir_q <= dir_q + 2'd1;
        BACKTRACK: begin
          sp_q               <= sp_q - (SPW+1)'(1);
          {pos_y_q, pos_x_q} <= bt_pos;
          dir_q              <= top_dir;
        end
        EMIT: if (path_valid && path_ready) emit_idx_q <= emit_idx_q + (SPW+1)'(1);
        default: ;
      endcase
    end
  end

  // Move history; contents are only meaningful below the stack pointer.
  always_ff @(posedge clk) begin
    if (state_q == ADVANCE && !sp_full) stack_mem[sp_q[SPW-1:0]] <= dir_q;
  end

endmodule

// File: tb/tb_maze_dfs_engine.sv
// Bench for maze_dfs_engine on a 4x4 grid. Expected path beats are queued
// by the stimulus and consumed by an independent monitor.
module tb_maze_dfs_engine;

  localparam int W = 4;

  logic         clk, rst, start, mem_rdata, mem_rvalid, path_ready, replay;
  logic [W-1:0] start_x, start_y, goal_x, goal_y;
  logic [7:0]   mem_addr;
  logic         mem_rd, mem_wr, path_valid, busy, done, fail, timeout;
  logic [1:0]   path_dir;
  logic [4:0]   path_len;

  maze_dfs_engine #(.W(W), .ROWS(4), .COLS(4), .DEPTH(16), .MAX_STEPS(1024)) dut (
    .clk(clk), .rst(rst), .start(start),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .path_dir(path_dir), .path_valid(path_valid), .path_ready(path_ready),
    .replay(replay), .busy(busy), .done(done), .fail(fail),
    .timeout(timeout), .path_len(path_len)
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic       cells [256];
  int         rd_lat = 1;
  int         rd_cnt = 0;
  logic [7:0] rd_addr = '0;
  bit         ready_toggle = 0;
  logic       stalled = 0;
  logic [1:0] stall_dir = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Maze memory: writes and read requests captured mid-cycle.
  always @(negedge clk) begin
    if (mem_wr) cells[mem_addr] = 1'b1;
    if (mem_rd) begin
      rd_addr = mem_addr;
      rd_cnt  = rd_lat;
    end
  end

  // Read data returned rd_lat cycles after the request.
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = cells[rd_addr];
      end
    end
  end

  // Path sink backpressure.
  always @(posedge clk) begin
    #1;
    if (ready_toggle) path_ready = ~path_ready;
    else              path_ready = 1'b1;
  end

  // Scoreboard monitor: path beats, stall stability, strobe exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd || mem_wr) begin
        checks++;
        if (mem_rd && mem_wr) begin
          errors++;
          $display("FAIL rd_wr_overlap actual=11 expected=not both");
        end
      end
      if (path_valid && stalled) begin
        checks++;
        if (path_dir != stall_dir) begin
          errors++;
          $display("FAIL stall_stable actual=%0d expected=%0d", path_dir, stall_dir);
        end
      end
      if (path_valid && path_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL path_beat actual=%0d expected=none", path_dir);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (path_dir != e) begin
            errors++;
            $display("FAIL path_beat actual=%0d expected=%0d", path_dir, e);
          end
        end
      end
      stalled   = path_valid && !path_ready;
      stall_dir = path_dir;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic load_maze(input logic [15:0] m);
    for (int i = 0; i < 256; i++) cells[i] = 1'b0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) cells[y*16 + x] = m[y*4 + x];
  endtask

  task automatic push_path(input logic [1:0] d[$]);
    foreach (d[i]) exp_q.push_back(d[i]);
  endtask

  task automatic go(input int sx, input int sy, input int gx, input int gy);
    @(posedge clk); #1;
    start_x = sx[W-1:0]; start_y = sy[W-1:0];
    goal_x  = gx[W-1:0]; goal_y  = gy[W-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int bound, output int cyc);
    cyc = 0;
    while (!(done || fail) && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_finished"}, int'(done || fail), 1);
  endtask

  task automatic do_replay();
    @(posedge clk); #1;
    replay = 1'b1;
    @(posedge clk); #1;
    replay = 1'b0;
  endtask

  task automatic status(input string name, input int e_done, input int e_fail, input int e_len);
    chk({name, "_done"}, int'(done), e_done);
    chk({name, "_fail"}, int'(fail), e_fail);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_timeout"}, int'(timeout), 0);
    chk({name, "_path_len"}, int'(path_len), e_len);
    chk({name, "_beats_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    logic [1:0] p[$];
    rst = 1'b1; start = 0; replay = 0; path_ready = 1;
    start_x = 0; start_y = 0; goal_x = 0; goal_y = 0;
    mem_rdata = 0; mem_rvalid = 0;
    load_maze(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_mem", int'({mem_rd, mem_wr, mem_addr}), 0);
    chk("rst_path_valid", int'(path_valid), 0);
    chk("rst_path_len", int'(path_len), 0);
    rst = 1'b0;

    // Open grid, straight run along x.
    load_maze(16'h0000);
    p = '{2'd0, 2'd0, 2'd0};
    push_path(p);
    go(0, 0, 3, 0);
    wait_end("open", 500, cyc);
    status("open", 1, 0, 3);
    chk("open_marked", int'(cells[8'h00] && cells[8'h01] && cells[8'h02]), 1);

    // Replay the same path.
    push_path(p);
    do_replay();
    chk("replay_done_low", int'(done), 0);
    wait_end("replay", 100, cyc);
    status("replay", 1, 0, 3);

    // Detour around a wall column, with backpressure.
    load_maze(16'h8AA2);
    ready_toggle = 1;
    p = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
    push_path(p);
    go(0, 0, 2, 0);
    wait_end("detour", 2000, cyc);
    status("detour", 1, 0, 8);
    ready_toggle = 0;

    // Goal sealed off: search exhausts and fails with no path beats.
    load_maze(16'h4800);
    go(0, 0, 3, 3);
    wait_end("sealed", 3000, cyc);
    status("sealed", 0, 1, 0);

    // Start on the goal.
    load_maze(16'h0000);
    go(2, 2, 2, 2);
    wait_end("same", 10, cyc);
    chk("same_latency_le3", int'(cyc <= 3), 1);
    status("same", 1, 0, 0);
    do_replay();
    wait_end("same_replay", 10, cyc);
    status("same_replay", 1, 0, 0);

    // Slow memory plus toggling ready.
    load_maze(16'h0000);
    rd_lat = 5;
    ready_toggle = 1;
    p = '{2'd0, 2'd0, 2'd0};
    push_path(p);
    go(0, 0, 3, 0);
    wait_end("slow", 2000, cyc);
    status("slow", 1, 0, 3);
    ready_toggle = 0;

    // Reset while a read is outstanding.
    load_maze(16'h0000);
    go(0, 0, 3, 0);
    cyc = 0;
    while (!mem_rd && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rd_seen", int'(mem_rd), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrd_busy", int'(busy), 0);
    chk("midrd_status", int'({done, fail, timeout, path_valid}), 0);
    chk("midrd_mem", int'({mem_rd, mem_wr, mem_addr}), 0);
    chk("midrd_path_len", int'(path_len), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("late_rvalid_busy", int'(busy), 0);
    chk("late_rvalid_mem", int'({mem_rd, mem_wr}), 0);

    // Clean run after reset.
    rd_lat = 1;
    load_maze(16'h0000);
    push_path(p);
    go(0, 0, 3, 0);
    wait_end("after_rst", 500, cyc);
    status("after_rst", 1, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
